// File: rtl/mem_pkg.sv
// Shared types and default parameters for the main-memory controller.
package mem_pkg;

  localparam int unsigned MEM_N_DEF       = 8;
  localparam int unsigned MEM_M_DEF       = 32;
  localparam int unsigned MEM_LATENCY_DEF = 2;
  localparam int unsigned LAT_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    READ_HOLD = 2'd2,
    CLEAR     = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Cache RAM-port bundle between the four-word cache (master) and mem_ctrl (slave).
interface mem_ctrl_if
  import mem_pkg::*;
#(
  parameter int unsigned n = MEM_N_DEF,
  parameter int unsigned m = MEM_M_DEF
) ();

  logic [n-1:0] addr_in;
  logic [m-1:0] data_in;
  logic         ce;
  logic         rw;
  logic         clr;
  logic [m-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         perr;

  modport master (
    output addr_in, data_in, ce, rw, clr,
    input  data_out, data_valid, busy, perr
  );

  modport slave (
    input  addr_in, data_in, ce, rw, clr,
    output data_out, data_valid, busy, perr
  );

endinterface

// File: rtl/mem_array.sv
// 2^AW x DW storage: synchronous single write port, combinational read port.
module mem_array #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; the controller's clear sequence wipes them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory controller behind the four-word cache: word writes, fixed-latency reads, full clear.
// Optional MEM_CTRL_PARITY_EN stores an even-parity bit per word and flags mismatches on read.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned n       = MEM_N_DEF,
  parameter int unsigned m       = MEM_M_DEF,
  parameter int unsigned LATENCY = MEM_LATENCY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_ctrl_if.slave  bus
);

`ifdef MEM_CTRL_PARITY_EN
  localparam int unsigned W = m + 1;
`else
  localparam int unsigned W = m;
`endif

  mem_state_t           state, state_d;
  logic [LAT_CNT_W-1:0] lat_cnt, lat_cnt_d;
  logic [n-1:0]         clr_cnt, clr_cnt_d;
  logic [n-1:0]         raddr, raddr_d;
  logic [m-1:0]         data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic                 we_c;
  logic [n-1:0]         waddr_c;
  logic [W-1:0]         wdata_c;
  logic [W-1:0]         wr_word_c;
  logic [W-1:0]         rdata_c;

`ifdef MEM_CTRL_PARITY_EN
  logic                 perr_q, perr_d;
  assign wr_word_c = {^bus.data_in, bus.data_in};
`else
  assign wr_word_c = bus.data_in;
`endif

  mem_array #(
    .AW (n),
    .DW (W)
  ) u_array (
    .clk   (clk),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (wdata_c),
    .raddr (raddr),
    .rdata (rdata_c)
  );

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      clr_cnt    <= '0;
      raddr      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MEM_CTRL_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      lat_cnt    <= lat_cnt_d;
      clr_cnt    <= clr_cnt_d;
      raddr      <= raddr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
`ifdef MEM_CTRL_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  // Next-state and next-output logic; clear request beats a new request, which beats holding.
  always_comb begin
    state_d    = state;
    lat_cnt_d  = lat_cnt;
    clr_cnt_d  = clr_cnt;
    raddr_d    = raddr;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    we_c       = 1'b0;
    waddr_c    = bus.addr_in;
    wdata_c    = wr_word_c;
`ifdef MEM_CTRL_PARITY_EN
    perr_d     = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (!bus.clr) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          busy_d    = 1'b1;
        end else if (bus.ce) begin
          if (bus.rw) begin
            raddr_d   = bus.addr_in;
            lat_cnt_d = LAT_CNT_W'(LATENCY - 1);
            state_d   = READ_WAIT;
            busy_d    = 1'b1;
          end else begin
            we_c = 1'b1;
          end
        end
      end

      READ_WAIT: begin
        if (!bus.clr) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          busy_d    = 1'b1;
        end else if (lat_cnt == '0) begin
          data_out_d = rdata_c[m-1:0];
          valid_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = READ_HOLD;
`ifdef MEM_CTRL_PARITY_EN
          perr_d     = ^rdata_c;
`endif
        end else begin
          lat_cnt_d = lat_cnt - LAT_CNT_W'(1);
        end
      end

      // Served read stays parked until the request is withdrawn or changes address.
      READ_HOLD: begin
        if (!bus.clr) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          busy_d    = 1'b1;
        end else if (!bus.ce || !bus.rw || (bus.addr_in != raddr)) begin
          state_d = IDLE;
        end
      end

      // One word per cycle; clr is not re-sampled while sweeping.
      CLEAR: begin
        we_c      = 1'b1;
        waddr_c   = clr_cnt;
        wdata_c   = '0;
        clr_cnt_d = clr_cnt + n'(1);
        if (clr_cnt == '1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
`ifdef MEM_CTRL_PARITY_EN
  assign bus.perr       = perr_q;
`else
  assign bus.perr       = 1'b0;
`endif

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Main-memory controller on the backside of the four-word cache. Accepts single-word read and write requests from the cache's RAM port (address, data, chip-enable, read/write, clear), stores words in an internal 2^n x m array, returns read data after a fixed latency with a one-cycle valid strobe, and runs a sequential clear of the whole array. It samples on the rising clock edge, so cache outputs launched on the falling edge are stable when sampled.

## Interface
- n, 8: address width; array depth 2^n words
- m, 32: data word width
- LATENCY, 2: read latency in cycles, from request acceptance to data_valid; legal range 1..15

- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- addr_in  in  n  request word address (from cache Address_to_RAM)
- data_in  in  m  write data (from cache Data_to_RAM)
- ce  in  1  chip enable; request present while high
- rw  in  1  1 = read, 0 = write; meaningful only while ce = 1
- clr  in  1  active-low clear request; 1 = normal
- data_out  out  m  read data (to cache Data_from_RAM); holds last returned word
- data_valid  out  1  one-cycle strobe marking a fresh word on data_out
- busy  out  1  high while a read or clear is in progress; new requests ignored
- perr  out  1  parity error on returned word (only with MEM_CTRL_PARITY_EN)

## Operation
- Reset values: state IDLE, data_out 0, data_valid 0, busy 0, perr 0, latency counter 0, clear counter 0. Array contents not reset.
- States: IDLE, READ_WAIT, READ_HOLD, CLEAR.
- Priority at every edge: clr = 0 > ce request > hold.
- IDLE, clr = 0: enter CLEAR, clear counter = 0, busy = 1.
- IDLE, ce = 1, rw = 0: write data_in to array[addr_in] at this edge; stay IDLE; busy stays 0. A held write rewrites the same word each cycle (idempotent).
- IDLE, ce = 1, rw = 1: latch addr_in, load counter with LATENCY-1, enter READ_WAIT, busy = 1.
- READ_WAIT: decrement counter; when counter is 0, drive data_out = array[latched addr], data_valid = 1 for that cycle, enter READ_HOLD.
- READ_HOLD: busy = 0. Return to IDLE when ce = 0, rw = 0, or addr_in differs from latched address. A held identical read is never re-served (one read per request).
- CLEAR: write 0 to array[counter] each cycle; counter increments n-bit, wraps from 2^n-1 to 0 on the final write; then IDLE, busy = 0. Takes exactly 2^n cycles; clr is sampled only to start.
- clr = 0 during READ_WAIT: abort read, no data_valid, enter CLEAR.
- clr = 0 during CLEAR: ignored (no restart).
- rst_n low mid-read or mid-clear: immediate return to reset values; partially cleared array remains as is.
- Read-after-write same address: read accepted the edge after the write returns the new data.

## Timing
- Write: committed at the accepting edge T; readable by a read accepted at T+1.
- Read accepted at edge T: data_valid high in the cycle after edge T+LATENCY; data_out stable from then until the next data_valid.
- data_valid never high two consecutive cycles.
- Clear started at edge T: busy high from T through T+2^n; first request accepted at edge T+2^n+1.

## Configuration
- MEM_CTRL_PARITY_EN defined: array is m+1 bits wide, even parity of data_in stored on every write (clear stores parity 0); on read return perr = parity mismatch, asserted with data_valid for one cycle; data_out still driven.
- Undefined: array m bits; perr tied 0.

## Structure
- Package mem_pkg: state enum (IDLE, READ_WAIT, READ_HOLD, CLEAR), default n/m/LATENCY constants, counter width constant (4 bits).
- One sub-module mem_array: synchronous-write, combinational-read 2^n x W storage with single write port (we, waddr, wdata) and one read address; mem_ctrl holds FSM, counters and parity logic.

## Test plan
- Write 0xDEADBEEF to 0x10, then read 0x10 next cycle -> data_valid exactly LATENCY cycles after acceptance, data_out = 0xDEADBEEF.
- Hold ce = 1, rw = 1, addr 0x10 for 10 cycles -> exactly one data_valid pulse; change addr to 0x11 -> second pulse.
- Write 0x5 to 0xFF, pulse clr = 0 one cycle -> busy high 256 cycles, read 0xFF returns 0x0, read 0x00 returns 0x0.
- Start read of 0x20, assert clr = 0 at next edge -> no data_valid, busy stays high through clear.
- rst_n low during READ_WAIT -> data_valid, busy, data_out all 0 immediately; no later strobe.
- MEM_CTRL_PARITY_EN: force array parity bit of 0x30 flipped after writing 0x1 -> read 0x30 gives data_out 0x1, perr = 1 with data_valid.
